// File: rtl/main_mem_arbiter.sv
// Single-port main memory arbiter between instruction fetch (IF) and memory access (MA).
// MA normally wins; a saturating starvation counter forces an IF grant; read data is steered to its owner.
module main_mem_arbiter #(
  parameter int MAIN_MEM_BYTE_ADD_W = 8,
  parameter int STARVE_MAX          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ma_req,
  input  logic        ma_wen,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdat,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [31:0] ma_rdata,
  output logic        mem_cs,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dat_in,
  input  logic [31:0] mem_dat_out
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } own_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || MAIN_MEM_BYTE_ADD_W < 2 || MAIN_MEM_BYTE_ADD_W > 32)
  begin : g_param_check
    $error("main_mem_arbiter: illegal parameter value");
  end

  own_t       rd_own, rd_own_nxt;
  logic [3:0] starve_cnt, starve_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_own     <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rd_own     <= rd_own_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    if_gnt     = 1'b0;
    ma_gnt     = 1'b0;
    mem_cs     = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    starve_nxt = starve_cnt;
    rd_own_nxt = OWN_NONE;

    // Grants are suppressed while reset is held so the memory sees no command.
    if (rst_n) begin
      if (if_req && (!ma_req || starve_cnt == STARVE_LIM)) begin
        if_gnt = 1'b1;
      end else if (ma_req) begin
        ma_gnt = 1'b1;
      end
    end

    if (if_gnt) begin
      mem_cs     = 1'b1;
      mem_addr   = if_addr;
      rd_own_nxt = OWN_IF;
    end else if (ma_gnt) begin
      mem_cs     = 1'b1;
      mem_wen    = ma_wen;
      mem_addr   = ma_addr;
      mem_dat_in = ma_wdat;
      rd_own_nxt = ma_wen ? OWN_NONE : OWN_MA;
    end

    if (if_gnt || !if_req) begin
      starve_nxt = '0;
    end else if (ma_gnt && starve_cnt < STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    if_rvalid = (rd_own == OWN_IF);
    ma_rvalid = (rd_own == OWN_MA);
    if_rdata  = if_rvalid ? mem_dat_out : '0;
    ma_rdata  = ma_rvalid ? mem_dat_out : '0;
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a behavioural one-cycle-latency memory
// and a queue of expected read responses checked one cycle after each grant.
module tb_main_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ma_req = 1'b0;
  logic        ma_wen = 1'b0;
  logic [31:0] ma_addr = '0;
  logic [31:0] ma_wdat = '0;
  logic        ma_gnt, ma_rvalid;
  logic [31:0] ma_rdata;
  logic        mem_cs, mem_wen;
  logic [31:0] mem_addr, mem_dat_in;
  logic [31:0] mem_dat_out = '0;

  main_mem_arbiter #(.MAIN_MEM_BYTE_ADD_W(10), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_wen(ma_wen), .ma_addr(ma_addr), .ma_wdat(ma_wdat), .ma_gnt(ma_gnt),
    .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  // Memory macro: writes on the edge, read data registered one cycle after the read.
  logic [31:0] mem_array [0:255];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_wen) mem_array[mem_addr[9:2]] <= mem_dat_in;
      else         mem_dat_out <= mem_array[mem_addr[9:2]];
    end
  end

  typedef struct { int unsigned own; logic [31:0] data; } resp_t;
  resp_t       exp_q[$];
  logic [31:0] model_mem [0:255];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic init_word(input logic [31:0] a, input logic [31:0] d);
    mem_array[a[9:2]] = d;
    model_mem[a[9:2]] = d;
  endtask

  // Sample at the falling edge: grants, memory command and the response owed from last cycle.
  task automatic cycle(input logic eg_if, input logic eg_ma, input string tag);
    resp_t e;
    logic  rd;
    @(negedge clk);
    chk({tag, " if_gnt"}, 32'(if_gnt), 32'(eg_if));
    chk({tag, " ma_gnt"}, 32'(ma_gnt), 32'(eg_ma));
    rd = eg_if || eg_ma;
    chk({tag, " mem_cs"}, 32'(mem_cs), 32'(rd));
    chk({tag, " mem_wen"}, 32'(mem_wen), 32'(eg_ma && ma_wen));
    chk({tag, " mem_addr"}, mem_addr, eg_if ? if_addr : (eg_ma ? ma_addr : 32'h0));
    chk({tag, " mem_dat_in"}, mem_dat_in, eg_ma ? ma_wdat : 32'h0);
    if (exp_q.size() == 0) begin
      chk({tag, " resp_queue_nonempty"}, 32'(exp_q.size()), 32'd1);
      e.own = 0; e.data = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'(e.own == 1));
    chk({tag, " if_rdata"}, if_rdata, (e.own == 1) ? e.data : 32'h0);
    chk({tag, " ma_rvalid"}, 32'(ma_rvalid), 32'(e.own == 2));
    chk({tag, " ma_rdata"}, ma_rdata, (e.own == 2) ? e.data : 32'h0);
    if (eg_if)                exp_q.push_back('{1, model_mem[if_addr[9:2]]});
    else if (eg_ma && !ma_wen) exp_q.push_back('{2, model_mem[ma_addr[9:2]]});
    else                      exp_q.push_back('{0, 32'h0});
    if (eg_ma && ma_wen) model_mem[ma_addr[9:2]] = ma_wdat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, " ma_gnt"}, 32'(ma_gnt), 32'd0);
    chk({tag, " mem_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_dat_in"}, mem_dat_in, 32'd0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, " if_rdata"}, if_rdata, 32'd0);
    chk({tag, " ma_rvalid"}, 32'(ma_rvalid), 32'd0);
    chk({tag, " ma_rdata"}, ma_rdata, 32'd0);
  endtask

  // Requester protocol: a request not granted must be held with stable attributes.
  logic        p_if_pend = 1'b0, p_ma_pend = 1'b0, p_ma_wen;
  logic [31:0] p_if_addr, p_ma_addr, p_ma_wdat;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_if_pend = 1'b0;
      p_ma_pend = 1'b0;
    end else begin
      if (p_if_pend) chk("proto if_req_held", {if_req, if_addr}, {1'b1, p_if_addr});
      if (p_ma_pend) chk("proto ma_req_held", {ma_req, ma_wen, ma_addr ^ ma_wdat},
                         {1'b1, p_ma_wen, p_ma_addr ^ p_ma_wdat});
      p_if_pend = if_req && !if_gnt;
      p_ma_pend = ma_req && !ma_gnt;
      p_if_addr = if_addr;
      p_ma_wen  = ma_wen;
      p_ma_addr = ma_addr;
      p_ma_wdat = ma_wdat;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = '0;
      model_mem[i] = '0;
    end
    init_word(32'h10, 32'hDEADBEEF);
    init_word(32'h00, 32'hA5A50000);
    init_word(32'h04, 32'h00005A5A);
    init_word(32'h30, 32'h30303030);
    init_word(32'h34, 32'h34343434);

    // Reset state with requests active: everything forced low.
    if_req = 1'b1; if_addr = 32'h10; ma_req = 1'b1; ma_wen = 1'b1; ma_addr = 32'h20; ma_wdat = 32'h1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    if_req = 1'b0; ma_req = 1'b0; ma_wen = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_q.push_back('{0, 32'h0});
    cycle(1'b0, 1'b0, "idle");

    if_req = 1'b1; if_addr = 32'h10;
    cycle(1'b1, 1'b0, "if_rd10");
    if_req = 1'b0;
    cycle(1'b0, 1'b0, "if_rd10_resp");

    ma_req = 1'b1; ma_wen = 1'b1; ma_addr = 32'h20; ma_wdat = 32'h12345678;
    cycle(1'b0, 1'b1, "ma_st20");
    ma_req = 1'b0; ma_wen = 1'b0;
    cycle(1'b0, 1'b0, "ma_st20_noresp");
    if_req = 1'b1; if_addr = 32'h20;
    cycle(1'b1, 1'b0, "if_rd20");
    if_req = 1'b0;
    cycle(1'b0, 1'b0, "if_rd20_resp");

    // Both held: IF wins every fifth cycle.
    if_req = 1'b1; if_addr = 32'h34; ma_req = 1'b1; ma_wen = 1'b0; ma_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      cycle((i % 5) == 4, (i % 5) != 4, $sformatf("starve%0d", i));
    end
    if_req = 1'b0; ma_req = 1'b0;
    cycle(1'b0, 1'b0, "starve_drain");

    if_req = 1'b1; if_addr = 32'h00;
    cycle(1'b1, 1'b0, "b2b_if");
    if_req = 1'b0; ma_req = 1'b1; ma_wen = 1'b0; ma_addr = 32'h04;
    cycle(1'b0, 1'b1, "b2b_ma");
    ma_req = 1'b0;
    cycle(1'b0, 1'b0, "b2b_drain");

    // Reset while an IF read is in flight: the response must be dropped.
    if_req = 1'b1; if_addr = 32'h10;
    cycle(1'b1, 1'b0, "rst_if_rd");
    if_req = 1'b0; ma_req = 1'b1; ma_wen = 1'b1; ma_addr = 32'h24; ma_wdat = 32'hFFFF0000;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    ma_req = 1'b0; ma_wen = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_q.push_back('{0, 32'h0});
    cycle(1'b0, 1'b0, "post_rst_idle");
    if_req = 1'b1; if_addr = 32'h34; ma_req = 1'b1; ma_wen = 1'b0; ma_addr = 32'h30;
    for (int i = 0; i < 5; i++) begin
      cycle(i == 4, i != 4, $sformatf("post_rst_starve%0d", i));
    end
    if_req = 1'b0; ma_req = 1'b0;
    cycle(1'b0, 1'b0, "final_drain");
    chk("model_store20", model_mem[8'h08], 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
